// File: rtl/mul_pkg.sv
// Shared types and helpers for the signed bit-serial multiplier sequencer.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_e;

  // Widest product the shared helper supports; callers slice down to 2*WIDTH.
  localparam int PP_W = 64;

  // b must already be sign-extended to PP_W bits by the caller.
  function automatic logic signed [PP_W-1:0] pp_shift(
    input logic                   a_bit,
    input logic signed [PP_W-1:0] b,
    input int unsigned            cnt
  );
    return a_bit ? (b <<< cnt) : '0;
  endfunction

endpackage

// File: rtl/mul_serial_ctrl_pp.sv
// One combinational step of the serial multiply: add the shifted partial
// product, or subtract it on the MSB whose weight is -2^(WIDTH-1).
module mul_serial_pp
  import mul_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNTW = $clog2(WIDTH)
) (
  input  logic                      a_bit,
  input  logic signed [WIDTH-1:0]   b_q,
  input  logic        [CNTW-1:0]    cnt,
  input  logic                      is_msb,
  input  logic signed [2*WIDTH-1:0] acc,
  output logic signed [2*WIDTH-1:0] acc_next
);

  logic signed [PP_W-1:0]    b_ext;
  logic signed [PP_W-1:0]    pp_full;
  logic signed [2*WIDTH-1:0] pp;
  logic                      unused_pp_hi;

  assign b_ext        = {{(PP_W-WIDTH){b_q[WIDTH-1]}}, b_q};
  assign pp_full      = pp_shift(a_bit, b_ext, 32'(cnt));
  assign pp           = pp_full[2*WIDTH-1:0];
  assign unused_pp_hi = ^pp_full[PP_W-1:2*WIDTH];

  assign acc_next = is_msb ? (acc - pp) : (acc + pp);

endmodule

// File: rtl/mul_serial_ctrl.sv
// Sequencer for the signed bit-serial multiplier: valid/ready in, WIDTH
// accumulate cycles, registered product held on a valid/ready output.
module mul_serial_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   i_data0,
  input  logic signed [WIDTH-1:0]   i_data1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] o_data,
  output logic                      busy
);

  localparam int CNTW = $clog2(WIDTH);

  mul_state_e                state_q, state_d;
  logic        [CNTW-1:0]    cnt_q;
  logic signed [2*WIDTH-1:0] acc_q;
  logic signed [2*WIDTH-1:0] acc_next;
  logic signed [WIDTH-1:0]   a_q;
  logic signed [WIDTH-1:0]   b_q;
  logic                      accept;
  logic                      is_msb;

  assign is_msb = (cnt_q == CNTW'(WIDTH-1));

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (is_msb) state_d = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a same-cycle accept.
    if (clr) begin
      state_d  = IDLE;
      in_ready = 1'b0;
    end
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (clr || accept) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_next;
      cnt_q <= is_msb ? '0 : cnt_q + CNTW'(1);
    end
  end

  // Operands are captured only on the accept edge and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= i_data0;
      b_q <= i_data1;
    end
  end

  mul_serial_pp #(.WIDTH(WIDTH)) u_pp (
    .a_bit    (a_q[cnt_q]),
    .b_q      (b_q),
    .cnt      (cnt_q),
    .is_msb   (is_msb),
    .acc      (acc_q),
    .acc_next (acc_next)
  );

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign o_data    = acc_q;

endmodule

// File: tb/tb_mul_serial_ctrl.sv
// Bench for mul_serial_ctrl: directed corner cases plus randomized traffic
// checked every cycle against a transaction-level model of the handshake.
module tb_mul_serial_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [W-1:0] i_data0 = '0;
  logic signed [W-1:0] i_data1 = '0;
  logic in_ready, out_valid, busy;
  logic signed [2*W-1:0] o_data;

  int n_cmp = 0;
  int n_bad = 0;

  mul_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i_data0   (i_data0),
    .i_data1   (i_data1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o_data    (o_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: cycles of work left, whether a finished product is waiting, and its value.
  int                  m_left = 0;
  bit                  m_done = 1'b0;
  logic signed [15:0]  m_prod = '0;
  logic signed [15:0]  m_run = '0;
  int                  m_accepts = 0;

  function automatic bit m_in_ready();
    return !clr && ((m_left == 0 && !m_done) || (m_done && out_ready));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= '0;
    end else if (clr) begin
      m_left <= 0;
      m_done <= 1'b0;
    end else begin
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_prod <= m_run;
        end
      end else if (m_done && out_ready) begin
        m_done <= 1'b0;
      end
      if (in_valid && m_in_ready()) begin
        m_left    <= W;
        m_run     <= 16'(int'(i_data0) * int'(i_data1));
        m_accepts <= m_accepts + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", longint'(busy), longint'(m_left > 0));
      chk("out_valid", longint'(out_valid), longint'(m_done));
      chk("in_ready", longint'(in_ready), longint'(m_in_ready()));
      if (m_done) chk("o_data", longint'(o_data), longint'(m_prod));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts at posedge+2; returns at posedge+2 with the product on o_data.
  task automatic op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                    input longint exp, input string nm, input logic hold_ready);
    int lat;
    int ir_bad;
    i_data0   = a;
    i_data1   = b;
    in_valid  = 1'b1;
    out_ready = hold_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    i_data0  = W'($urandom);
    i_data1  = W'($urandom);
    lat      = 0;
    ir_bad   = 0;
    repeat (20) begin
      if (out_valid) break;
      if (in_ready) ir_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " latency"}, longint'(lat), longint'(W));
    chk({nm, " in_ready low while running"}, longint'(ir_bad), 0);
    chk({nm, " product"}, longint'(o_data), exp);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [2*W-1:0] saved;
    int base;
    bit reached;
    logic signed [W-1:0] corners [4];
    corners[0] = -8'sd128;
    corners[1] = 8'sd127;
    corners[2] = -8'sd1;
    corners[3] = 8'sd0;

    #3;
    chk("reset in_ready", longint'(in_ready), 1);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset o_data", longint'(o_data), 0);
    #20 rst_n = 1'b1;
    tick();

    op(8'sd3, 8'sd5, 15, "3x5", 1'b1);
    tick();
    chk("3x5 back to idle", longint'(in_ready), 1);

    op(-8'sd128, -8'sd128, 16384, "-128x-128", 1'b1);  tick();
    op(-8'sd128, 8'sd127, -16256, "-128x127", 1'b1);   tick();
    op(8'sd127, -8'sd1, -127, "127x-1", 1'b1);         tick();
    op(8'sd0, -8'sd128, 0, "0x-128", 1'b1);            tick();

    // Backpressure
    op(-8'sd7, 8'sd6, -42, "bp", 1'b0);
    saved = o_data;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp o_data stable", longint'(o_data), longint'(saved));
      chk("bp in_ready low", longint'(in_ready), 0);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp released out_valid", longint'(out_valid), 0);
    chk("bp released in_ready", longint'(in_ready), 1);
    #1;

    // Back-to-back through DONE
    op(8'sd11, -8'sd3, -33, "b2b first", 1'b0);
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready follows out_ready", longint'(in_ready), 1);
    op(-8'sd5, 8'sd9, -45, "b2b second", 1'b1);
    tick();

    // Abort at cnt=4
    i_data0  = 8'sd7;
    i_data1  = 8'sd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clr      = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("clr masks in_ready", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("abort busy", longint'(busy), 0);
    chk("abort out_valid", longint'(out_valid), 0);
    clr      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort in_ready", longint'(in_ready), 1);
    op(8'sd2, 8'sd2, 4, "post-abort 2x2", 1'b1);
    tick();

    // Asynchronous reset mid-run
    i_data0  = -8'sd100;
    i_data1  = 8'sd50;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("async rst busy", longint'(busy), 0);
    chk("async rst out_valid", longint'(out_valid), 0);
    chk("async rst in_ready", longint'(in_ready), 1);
    chk("async rst o_data", longint'(o_data), 0);
    #3;
    rst_n = 1'b1;
    tick();
    op(-8'sd3, 8'sd7, -21, "post-reset", 1'b1);
    tick();

    // Randomized traffic
    base    = m_accepts;
    reached = 1'b0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      if (m_accepts >= base + 1000) begin
        reached = 1'b1;
        break;
      end
      in_valid  = ($urandom_range(3) != 0);
      i_data0   = ($urandom_range(7) == 0) ? corners[$urandom_range(3)] : W'($urandom);
      i_data1   = ($urandom_range(7) == 0) ? corners[$urandom_range(3)] : W'($urandom);
      out_ready = ($urandom_range(2) != 0);
      clr       = ($urandom_range(96) == 0);
      tick();
    end
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("random accept count reached", longint'(reached), 1);
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_serial_ctrl.md
# mul_serial_ctrl

Sequencer for the signed bit-serial multiplier datapath: accepts one operand pair over a valid/ready handshake, steps a bit counter over the multiplier operand for WIDTH cycles, and accumulates shifted, sign-corrected partial products into a 2·WIDTH-bit signed product. The product is presented on a valid/ready output handshake. The block sits between the systolic PE operand registers and the PE accumulator. It replaces the free-running bit counter with a controlled, abortable, back-to-back-capable schedule.

## Interface
- WIDTH, 8: operand width in bits, signed two's complement; must be ≥ 2.
- CNTW, $clog2(WIDTH): bit-counter width; local, derived, not overridable.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- i_data0  in  WIDTH  signed multiplier; scanned one bit per cycle, LSB first.
- i_data1  in  WIDTH  signed multiplicand.
- out_valid  out  1  o_data holds a completed product.
- out_ready  in  1  consumer accepts the product.
- o_data  out  2·WIDTH  signed product i_data0 × i_data1.
- busy  out  1  high in RUN.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid, the block latches i_data0/i_data1, sets cnt=0, sets acc=0 and goes to RUN.
- RUN: each cycle it computes pp = a_q[cnt] ? sext(b_q) << cnt : 0, extended to 2·WIDTH bits.
  - For cnt < WIDTH-1: acc ← acc + pp.
  - For cnt = WIDTH-1: acc ← acc − pp, because the MSB carries weight −2^(WIDTH-1).
  - cnt increments each cycle. After the cnt=WIDTH-1 update, the FSM goes to DONE and cnt returns to 0.
- DONE: out_valid=1 and o_data=acc, both held stable until out_ready.
  - On out_ready without in_valid: go to IDLE.
  - On out_ready with in_valid: latch the new operands, clear acc and go straight to RUN (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is low throughout RUN.
- Operands are sampled only on the accept edge. Later changes on i_data0/i_data1 have no effect on the product in flight.
- clr has priority over every other event in every state. When asserted, the next state is IDLE, cnt=0 and acc=0; any product in flight or pending is discarded. An in_valid on the same cycle is not accepted, because in_ready is forced to 0 while clr=1.
- All arithmetic is 2·WIDTH-bit two's complement. No overflow is possible, including −2^(WIDTH-1) × −2^(WIDTH-1) = 2^(2·WIDTH-2).

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, o_data=0. Internally state=IDLE, cnt=0 and acc=0.
- Latency: if the accept edge is edge 0, out_valid rises after edge WIDTH. For WIDTH=8 the result is valid 8 cycles after acceptance.
- Throughput: one product per WIDTH+1 cycles when out_ready is held high and in_valid is continuous. The DONE→RUN shortcut saves the IDLE cycle.
- o_data is registered, with no combinational path from inputs to o_data.
- in_ready depends combinationally on out_ready in DONE only.
- Asynchronous reset mid-RUN behaves identically to clr: no partial result is ever presented.

## Structure
- Shared package mul_pkg holds:
  - the FSM state enum mul_state_e (IDLE, RUN, DONE);
  - a function pp_shift(bit, b, cnt) returning the sign-extended, shifted partial product.
- Sub-module mul_serial_pp is the combinational partial-product/accumulate step. Its inputs are a_bit, b_q, cnt, is_msb and acc. Its output is acc_next, which performs the add or subtract.
- The top level holds the FSM, the operand registers, cnt and acc.

## Test plan
- Basic, WIDTH=8: accept 3 × 5 with out_ready=1.
  - out_valid rises exactly 8 cycles after the accept edge, with o_data=15.
  - in_ready is low for cycles 1–8.
- Sign corners:
  - −128 × −128 gives 16384.
  - −128 × 127 gives −16256.
  - 127 × −1 gives −127.
  - 0 × −128 gives 0.
  - Random signed pairs (≥1000) match a golden model.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - o_data stays stable and in_ready stays 0.
  - When out_ready=1, the next cycle returns to IDLE.
- Back-to-back: hold in_valid high with a new pair already presented when out_ready rises in DONE.
  - The second pair is accepted on the same edge, and its result appears 8 cycles later.
- Abort: assert clr at cnt=4 of 7 × 9.
  - The next cycle shows state IDLE, busy=0 and out_valid=0.
  - A following 2 × 2 yields 4, with no residue from the aborted product.
- Reset mid-RUN: drop rst_n asynchronously mid-cycle.
  - Outputs immediately take their reset values.
  - After release, the first operation completes correctly.
